// File: rtl/cache_types.sv
// Types shared by the snoop bus, the cache controller and the snoop responder.
package cache_types;

  localparam int NUM_CACHE        = 4;
  localparam int XLEN             = 32;
  localparam int SRC_BITS         = (NUM_CACHE > 1) ? $clog2(NUM_CACHE) : 1;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int SET_INDEX_BITS   = 4;
  localparam int TAG_BITS         = XLEN - LINE_OFFSET_BITS - SET_INDEX_BITS;

  typedef enum logic [1:0] {
    GETS = 2'd0,
    GETM = 2'd1,
    PUTM = 2'd2
  } bus_tx_t;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_state_t;

  typedef struct packed {
    logic                valid;
    logic [SRC_BITS-1:0] source;
    logic [XLEN-1:0]     addr;
    bus_tx_t             bus_tx;
  } bus_msg_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    msi_state_t          state;
  } tag_entry_t;

  // Buffered snoop: the source is already filtered away before enqueue.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    bus_tx_t         bus_tx;
  } snoop_req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } snoop_fsm_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/snoop_fifo.sv
// Synchronous FIFO for incoming snoops; almost_full is registered and
// anticipates the one message already in flight behind the bus register.
module snoop_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             almost_full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Extra wrap bit makes the pointer difference the true occupancy.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      almost_full <= (count_next >= (AW+1)'(DEPTH - 1));
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/snoop_responder.sv
// Snoop bus receive end for one MSI cache node: buffers foreign snoops,
// downgrades/invalidates lines, flushes owned lines, reports own ordering.
// Optional perf counters: define SNOOP_RESPONDER_PERF_EN.
module snoop_responder
  import cache_types::*;
#(
  parameter int NODE_ID     = 0,
  parameter int NUM_NODES   = NUM_CACHE,
  parameter int FIFO_DEPTH  = 4,
  parameter int OFFSET_BITS = LINE_OFFSET_BITS,
  parameter int INDEX_BITS  = SET_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  bus_msg_t              bus_msg,
  output logic                  snoop_full,
  input  logic                  tag_gnt,
  output logic                  tag_rd_en,
  output logic [INDEX_BITS-1:0] tag_rd_idx,
  input  tag_entry_t            tag_rd_data,
  output logic                  tag_wr_en,
  output logic [INDEX_BITS-1:0] tag_wr_idx,
  output msi_state_t            tag_wr_state,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_addr,
  output logic                  own_valid,
  output bus_tx_t               own_tx
`ifdef SNOOP_RESPONDER_PERF_EN
  ,
  output logic [31:0]           perf_snoop_hits,
  output logic [31:0]           perf_invalidations,
  output logic [31:0]           perf_flushes
`endif
);

  localparam int TAG_W = XLEN - OFFSET_BITS - INDEX_BITS;
  localparam logic [XLEN-1:0] LINE_MASK = ~((XLEN)'((64'd1 << OFFSET_BITS) - 64'd1));

  snoop_fsm_t      state_q;
  snoop_fsm_t      state_d;
  logic [XLEN-1:0] work_addr_q;
  bus_tx_t         work_tx_q;
  snoop_req_t      enq_req;
  snoop_req_t      head;
  logic            is_own;
  logic            is_foreign;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            hit;

  assign is_own     = bus_msg.valid && (bus_msg.source == SRC_BITS'(NODE_ID));
  assign is_foreign = bus_msg.valid && !is_own;
  assign enq_req    = '{addr: bus_msg.addr, bus_tx: bus_msg.bus_tx};

  snoop_fifo #(
    .WIDTH ($bits(snoop_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (is_foreign),
    .din         (enq_req),
    .pop         (fifo_pop),
    .dout        (head),
    .full        (fifo_full),
    .almost_full (snoop_full),
    .empty       (fifo_empty)
  );

  assign hit = tag_rd_data.valid && (tag_rd_data.tag == work_addr_q[XLEN-1 -: TAG_W]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    tag_rd_en    = 1'b0;
    tag_rd_idx   = '0;
    tag_wr_en    = 1'b0;
    tag_wr_idx   = '0;
    tag_wr_state = MSI_I;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && tag_gnt) begin
          tag_rd_en  = 1'b1;
          tag_rd_idx = head.addr[OFFSET_BITS +: INDEX_BITS];
          fifo_pop   = 1'b1;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        state_d    = ST_IDLE;
        tag_wr_idx = work_addr_q[OFFSET_BITS +: INDEX_BITS];
        if (hit && tag_rd_data.state == MSI_M && work_tx_q == GETS) begin
          tag_wr_en    = 1'b1;
          tag_wr_state = MSI_S;
          state_d      = ST_RESP;
        end else if (hit && tag_rd_data.state == MSI_M && work_tx_q == GETM) begin
          tag_wr_en    = 1'b1;
          tag_wr_state = MSI_I;
          state_d      = ST_RESP;
        end else if (hit && tag_rd_data.state == MSI_S && work_tx_q == GETM) begin
          tag_wr_en    = 1'b1;
          tag_wr_state = MSI_I;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Working copy is line-aligned on load so it doubles as the flush address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_addr_q <= '0;
      work_tx_q   <= GETS;
    end else if (fifo_pop) begin
      work_addr_q <= head.addr & LINE_MASK;
      work_tx_q   <= head.bus_tx;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_addr  = work_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_valid <= 1'b0;
      own_tx    <= GETS;
    end else begin
      own_valid <= is_own;
      own_tx    <= is_own ? bus_msg.bus_tx : GETS;
    end
  end

`ifdef SNOOP_RESPONDER_PERF_EN
  logic lookup_hit;
  logic lookup_inval;
  logic lookup_flush;

  assign lookup_hit   = (state_q == ST_LOOKUP) && hit;
  assign lookup_inval = tag_wr_en && (tag_wr_state == MSI_I);
  assign lookup_flush = (state_q == ST_LOOKUP) && (state_d == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_snoop_hits    <= '0;
      perf_invalidations <= '0;
      perf_flushes       <= '0;
    end else begin
      if (lookup_hit)   perf_snoop_hits    <= sat_inc(perf_snoop_hits);
      if (lookup_inval) perf_invalidations <= sat_inc(perf_invalidations);
      if (lookup_flush) perf_flushes       <= sat_inc(perf_flushes);
    end
  end
`endif

  resp_stable_a: assert property (@(posedge clk) disable iff (rst)
    resp_valid && !resp_ready |=> $stable(resp_addr));
  wr_in_lookup_a: assert property (@(posedge clk) disable iff (rst)
    tag_wr_en |-> state_q == ST_LOOKUP);
  source_range_a: assert property (@(posedge clk) disable iff (rst)
    bus_msg.valid |-> int'(bus_msg.source) < NUM_NODES);
  no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(is_foreign && fifo_full));

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: directed MSI cases, then random traffic
// checked against a line-state model of the cache.
module tb_snoop_responder;
  import cache_types::*;

  localparam int NODE_ID    = 0;
  localparam int FIFO_DEPTH = 4;
  localparam int OFF        = LINE_OFFSET_BITS;
  localparam int IDX        = SET_INDEX_BITS;
  localparam int SETS       = 1 << IDX;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  bus_msg_t        bus_msg;
  logic            snoop_full;
  logic            tag_gnt;
  logic            tag_rd_en;
  logic [IDX-1:0]  tag_rd_idx;
  tag_entry_t      tag_rd_data;
  logic            tag_wr_en;
  logic [IDX-1:0]  tag_wr_idx;
  msi_state_t      tag_wr_state;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_addr;
  logic            own_valid;
  bus_tx_t         own_tx;
`ifdef SNOOP_RESPONDER_PERF_EN
  logic [31:0]     perf_snoop_hits;
  logic [31:0]     perf_invalidations;
  logic [31:0]     perf_flushes;
`endif

  snoop_responder #(
    .NODE_ID    (NODE_ID),
    .NUM_NODES  (NUM_CACHE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .OFFSET_BITS(OFF),
    .INDEX_BITS (IDX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_msg     (bus_msg),
    .snoop_full  (snoop_full),
    .tag_gnt     (tag_gnt),
    .tag_rd_en   (tag_rd_en),
    .tag_rd_idx  (tag_rd_idx),
    .tag_rd_data (tag_rd_data),
    .tag_wr_en   (tag_wr_en),
    .tag_wr_idx  (tag_wr_idx),
    .tag_wr_state(tag_wr_state),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_addr   (resp_addr),
    .own_valid   (own_valid),
    .own_tx      (own_tx)
`ifdef SNOOP_RESPONDER_PERF_EN
    ,
    .perf_snoop_hits   (perf_snoop_hits),
    .perf_invalidations(perf_invalidations),
    .perf_flushes      (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX-1:0] idx;
    msi_state_t     st;
  } wr_exp_t;

  logic [IDX-1:0]  rd_q[$];
  wr_exp_t         wr_q[$];
  logic [XLEN-1:0] resp_q[$];
  bus_tx_t         own_q[$];

  tag_entry_t      model_mem [SETS];
  tag_entry_t      tag_mem   [SETS];
  logic            preload_en = 1'b0;
  logic [IDX-1:0]  preload_idx;
  tag_entry_t      preload_val;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // The cache's tag array: one-cycle read latency, state writes from the DUT.
  always @(posedge clk) begin
    tag_rd_data <= tag_rd_en ? tag_mem[tag_rd_idx] : '0;
    if (tag_wr_en)  tag_mem[tag_wr_idx].state <= tag_wr_state;
    if (preload_en) tag_mem[preload_idx] <= preload_val;
  end

  // Monitor: compares every DUT event against the head of its expectation queue.
  logic [IDX-1:0]  m_idx;
  wr_exp_t         m_wr;
  logic [XLEN-1:0] m_addr;
  bus_tx_t         m_tx;
  always @(negedge clk) begin
    if (!rst) begin
      if (tag_rd_en) begin
        check("rd_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
          m_idx = rd_q.pop_front();
          check("rd_idx", 64'(tag_rd_idx), 64'(m_idx));
        end
      end
      if (tag_wr_en) begin
        check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          m_wr = wr_q.pop_front();
          check("wr_idx", 64'(tag_wr_idx), 64'(m_wr.idx));
          check("wr_state", 64'(tag_wr_state), 64'(m_wr.st));
        end
      end
      if (resp_valid && resp_ready) begin
        check("resp_expected", 64'(resp_q.size() != 0), 64'd1);
        if (resp_q.size() != 0) begin
          m_addr = resp_q.pop_front();
          check("resp_addr", 64'(resp_addr), 64'(m_addr));
        end
      end
      if (own_valid) begin
        check("own_expected", 64'(own_q.size() != 0), 64'd1);
        if (own_q.size() != 0) begin
          m_tx = own_q.pop_front();
          check("own_tx", 64'(own_tx), 64'(m_tx));
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [TAG_BITS-1:0] tag, input msi_state_t st);
    model_mem[idx] = '{valid: 1'b1, tag: tag, state: st};
    @(posedge clk); #1;
    preload_idx = IDX'(idx);
    preload_val = model_mem[idx];
    preload_en  = 1'b1;
    @(posedge clk); #1;
    preload_en  = 1'b0;
  endtask

  // Drives one bus message for the current cycle and records what the cache must see.
  task automatic drive(input int src, input logic [XLEN-1:0] addr, input bus_tx_t tx);
    int idx;
    logic [TAG_BITS-1:0] tag;
    tag_entry_t e;
    bus_msg.valid  = 1'b1;
    bus_msg.source = src[SRC_BITS-1:0];
    bus_msg.addr   = addr;
    bus_msg.bus_tx = tx;
    if (src == NODE_ID) begin
      own_q.push_back(tx);
    end else begin
      idx = int'(addr / (1 << OFF)) % SETS;
      tag = TAG_BITS'(addr / (1 << (OFF + IDX)));
      e   = model_mem[idx];
      rd_q.push_back(IDX'(idx));
      if (e.valid && e.tag == tag) begin
        if (e.state == MSI_M && tx != PUTM) begin
          model_mem[idx].state = (tx == GETS) ? MSI_S : MSI_I;
          wr_q.push_back('{idx: IDX'(idx), st: model_mem[idx].state});
          resp_q.push_back(addr - (addr % (1 << OFF)));
        end else if (e.state == MSI_S && tx == GETM) begin
          model_mem[idx].state = MSI_I;
          wr_q.push_back('{idx: IDX'(idx), st: MSI_I});
        end
      end
    end
  endtask

  task automatic issue(input int src, input logic [XLEN-1:0] addr, input bus_tx_t tx);
    @(posedge clk); #1;
    drive(src, addr, tx);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus_msg.valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rd_q.size() + wr_q.size() + resp_q.size() + own_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_msg    = '0;
    tag_gnt    = 1'b1;
    resp_ready = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      preload(i, TAG_BITS'($urandom_range(32'h13, 32'h12)), msi_state_t'($urandom_range(2, 0)));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_tag_rd_en", 64'(tag_rd_en), 64'd0);
    check("rst_tag_rd_idx", 64'(tag_rd_idx), 64'd0);
    check("rst_tag_wr_en", 64'(tag_wr_en), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_addr", 64'(resp_addr), 64'd0);
    check("rst_own_valid", 64'(own_valid), 64'd0);
    check("rst_snoop_full", 64'(snoop_full), 64'd0);

    // Foreign GETS on an M line: read, downgrade to S, flush.
    preload(3, TAG_BITS'(32'h12), MSI_M);
    issue(1, 32'h0000_1230, GETS);
    idle();
    @(negedge clk);
    check("t1_rd_en_n1", 64'(tag_rd_en), 64'd1);
    check("t1_rd_idx_n1", 64'(tag_rd_idx), 64'd3);
    @(negedge clk);
    check("t1_wr_en_n2", 64'(tag_wr_en), 64'd1);
    check("t1_wr_state_n2", 64'(tag_wr_state), 64'(MSI_S));
    @(negedge clk);
    check("t1_resp_valid_n3", 64'(resp_valid), 64'd1);
    check("t1_resp_addr_n3", 64'(resp_addr), 64'h1230);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    check("t1_idle_after_hs", 64'(resp_valid), 64'd0);

    // Foreign GETM on an S line: invalidate, no flush.
    preload(5, TAG_BITS'(32'h12), MSI_S);
    issue(2, 32'h0000_1258, GETM);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("t2_wr_en_n2", 64'(tag_wr_en), 64'd1);
    check("t2_wr_state_n2", 64'(tag_wr_state), 64'(MSI_I));
    @(negedge clk);
    check("t2_no_resp_n3", 64'(resp_valid), 64'd0);

    // Own GETM: ordering report only.
    issue(NODE_ID, 32'h0000_1230, GETM);
    idle();
    @(negedge clk);
    check("t3_own_valid_n1", 64'(own_valid), 64'd1);
    check("t3_own_tx_n1", 64'(own_tx), 64'(GETM));
    check("t3_no_rd_n1", 64'(tag_rd_en), 64'd0);
    @(negedge clk);
    check("t3_own_pulse", 64'(own_valid), 64'd0);

    // PUTM from another node on an M line, then a miss: no writes, no flush.
    preload(6, TAG_BITS'(32'h12), MSI_M);
    issue(2, 32'h0000_1260, PUTM);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("t4_putm_no_wr", 64'(tag_wr_en), 64'd0);
    @(negedge clk);
    check("t4_putm_no_resp", 64'(resp_valid), 64'd0);
    issue(3, 32'h0000_5570, GETM);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("t4_miss_no_wr", 64'(tag_wr_en), 64'd0);
    @(negedge clk);
    check("t4_miss_no_resp", 64'(resp_valid), 64'd0);

    // Four back-to-back snoops with the tag port withheld.
    tag_gnt    = 1'b0;
    resp_ready = 1'b1;
    preload(1, TAG_BITS'(32'h12), MSI_M);
    preload(2, TAG_BITS'(32'h12), MSI_S);
    issue(1, 32'h0000_1214, GETM);
    issue(2, 32'h0000_1220, GETM);
    issue(3, 32'h0000_1310, GETS);
    check("t5_not_full_after_2", 64'(snoop_full), 64'd0);
    issue(1, 32'h0000_1260, GETS);
    check("t5_full_after_3", 64'(snoop_full), 64'd1);
    idle();
    check("t5_full_after_4", 64'(snoop_full), 64'd1);
    @(negedge clk);
    check("t5_hold_no_rd", 64'(tag_rd_en), 64'd0);
    @(posedge clk); #1 tag_gnt = 1'b1;
    drain(60);
    check("t5_full_cleared", 64'(snoop_full), 64'd0);

    // Reset while a flush waits on the data network, with a snoop still queued.
    resp_ready = 1'b0;
    preload(8, TAG_BITS'(32'h12), MSI_M);
    issue(1, 32'h0000_1284, GETM);
    issue(2, 32'h0000_5590, GETS);
    idle();
    @(negedge clk);
    check("t6_wr_before_rst", 64'(tag_wr_en), 64'd1);
    @(negedge clk);
    check("t6_resp_before_rst", 64'(resp_valid), 64'd1);
    #2 rst = 1'b1;
    rd_q.delete();
    wr_q.delete();
    resp_q.delete();
    own_q.delete();
    #1;
    check("t6_resp_dropped", 64'(resp_valid), 64'd0);
    check("t6_fifo_empty", 64'(tag_rd_en), 64'd0);
    check("t6_not_full", 64'(snoop_full), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_idle_after_rst", 64'(tag_rd_en | resp_valid), 64'd0);
    end

    // Random traffic: hits and misses over two tags, random handshakes.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      tag_gnt    = ($urandom_range(99, 0) < 70);
      resp_ready = ($urandom_range(99, 0) < 60);
      if (!snoop_full && $urandom_range(1, 0) == 1) begin
        drive(int'($urandom_range(NUM_CACHE - 1, 0)),
              {TAG_BITS'($urandom_range(32'h13, 32'h12)), IDX'($urandom_range(SETS - 1, 0)),
               OFF'($urandom_range((1 << OFF) - 1, 0))},
              bus_tx_t'($urandom_range(2, 0)));
      end else begin
        bus_msg.valid = 1'b0;
      end
    end
    idle();
    tag_gnt    = 1'b1;
    resp_ready = 1'b1;
    drain(200);
    check("end_rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("end_resp_q_empty", 64'(resp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
